rv32_reg_file: RTL and testbench



---
 rtl/rv32_reg_file.sv | 47 ++++
 tb/tb_rv32_reg_file.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/rv32_reg_file.sv
// RV32I integer register file: 32 x 32-bit, two combinational read ports,
// one synchronous write port, x0 hardwired to zero.
module rv32_reg_file #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_reg,
  input  logic [XLEN-1:0]   wr_data,
  input  logic [ADDR_W-1:0] rd_reg_1,
  input  logic [ADDR_W-1:0] rd_reg_2,
  output logic [XLEN-1:0]   rd_data_1,
  output logic [XLEN-1:0]   rd_data_2
);

  logic [NUM_REGS-1:0][XLEN-1:0] reg_view;

  // x0 has no storage at all, so no write path can ever disturb it.
  assign reg_view[0] = '0;

  for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
    logic [XLEN-1:0] reg_q;
    logic [XLEN-1:0] reg_d;
    logic            wr_hit;

    assign wr_hit = wr_en && (wr_reg == ADDR_W'(gi));
    assign reg_d  = wr_hit ? wr_data : reg_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign reg_view[gi] = reg_q;
  end

  // Reads see only committed state: a same-cycle write shows up after the edge.
  assign rd_data_1 = reg_view[rd_reg_1];
  assign rd_data_2 = reg_view[rd_reg_2];

endmodule

// File: tb/tb_rv32_reg_file.sv
// Directed-vector and random regression bench for rv32_reg_file.
// Inputs are driven on the falling edge and reads sampled 1ns later.
module tb_rv32_reg_file;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_reg;
  logic [31:0] wr_data;
  logic [4:0]  rd_reg_1;
  logic [4:0]  rd_reg_2;
  logic [31:0] rd_data_1;
  logic [31:0] rd_data_2;

  int n_vec;
  int n_err;

  rv32_reg_file #(.XLEN(32), .NUM_REGS(32), .ADDR_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .rd_reg_1  (rd_reg_1),
    .rd_reg_2  (rd_reg_2),
    .rd_data_1 (rd_data_1),
    .rd_data_2 (rd_data_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [13];
  logic [31:0] model [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] wreg, input logic [31:0] wdata,
                       input logic [4:0] r1, input logic [4:0] r2);
    wr_en    = we;
    wr_reg   = wreg;
    wr_data  = wdata;
    rd_reg_1 = r1;
    rd_reg_2 = r2;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    // Expected reads are the values BEFORE the edge that commits this row's write.
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  32'h00000000, 32'h00000000};
    vecs[1]  = '{1'b0, 5'd5,  32'h00000000, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 5'd0,  32'h00000000, 5'd4,  5'd6,  32'h00000000, 32'h00000000};
    vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
    vecs[4]  = '{1'b0, 5'd0,  32'h00000000, 5'd0,  5'd0,  32'h00000000, 32'h00000000};
    vecs[5]  = '{1'b1, 5'd7,  32'h12345678, 5'd7,  5'd5,  32'h00000000, 32'hDEADBEEF};
    vecs[6]  = '{1'b0, 5'd7,  32'hAAAAAAAA, 5'd7,  5'd7,  32'h12345678, 32'h12345678};
    vecs[7]  = '{1'b1, 5'd3,  32'h11111111, 5'd7,  5'd3,  32'h12345678, 32'h00000000};
    vecs[8]  = '{1'b1, 5'd3,  32'h22222222, 5'd3,  5'd3,  32'h11111111, 32'h11111111};
    vecs[9]  = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd3,  5'd31, 32'h22222222, 32'h00000000};
    vecs[10] = '{1'b0, 5'd31, 32'h00000000, 5'd31, 5'd1,  32'hCAFEF00D, 32'h00000000};
    vecs[11] = '{1'b1, 5'd1,  32'h00000001, 5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D};
    vecs[12] = '{1'b0, 5'd0,  32'h00000000, 5'd1,  5'd7,  32'h00000001, 32'h12345678};

    // Reset with a write pending: the write must be discarded.
    rst_n = 1'b0;
    drive(1'b1, 5'd9, 32'h99999999, 5'd9, 5'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset_hold_rd1", rd_data_1, 32'h0);
    drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      #1;
      check($sformatf("reset_rd1_x%0d", i), rd_data_1, 32'h0);
      check($sformatf("reset_rd2_x%0d", 31 - i), rd_data_2, 32'h0);
    end

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].wreg, vecs[i].wdata, vecs[i].r1, vecs[i].r2);
      #1;
      check($sformatf("vec%0d_rd1", i), rd_data_1, vecs[i].e1);
      check($sformatf("vec%0d_rd2", i), rd_data_2, vecs[i].e2);
    end

    // Read-during-write: new value visible right after the committing edge.
    @(negedge clk);
    drive(1'b1, 5'd3, 32'h33333333, 5'd3, 5'd3);
    #1;
    check("rdw_before_edge", rd_data_1, 32'h22222222);
    @(posedge clk);
    #1;
    check("rdw_after_edge_rd1", rd_data_1, 32'h33333333);
    check("rdw_after_edge_rd2", rd_data_2, 32'h33333333);
    wr_en = 1'b0;

    // Asynchronous reset mid-cycle clears state without waiting for a clock edge.
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    #1;
    check("pre_areset_x5", rd_data_1, 32'hDEADBEEF);
    #1;
    rst_n = 1'b0;
    #1;
    check("areset_x5", rd_data_1, 32'h0);
    check("areset_x31", rd_data_2, 32'h0);
    drive(1'b1, 5'd10, 32'h0BADC0DE, 5'd10, 5'd10);
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    rst_n = 1'b1;
    #1;
    check("reset_write_dropped", rd_data_1, 32'h0);

    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    for (int i = 0; i < 1000; i++) begin
      logic        we;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      logic [4:0]  r1;
      logic [4:0]  r2;
      wdata = $urandom;
      if (i < 96) begin
        // Deterministic sweep guarantees every index on every port, including x0 writes.
        we   = (i % 5) != 4;
        wreg = 5'((i * 3) % 32);
        r1   = 5'(i % 32);
        r2   = 5'((i + 7) % 32);
      end else begin
        we   = ($urandom % 4) != 0;
        wreg = 5'($urandom);
        r1   = 5'($urandom);
        r2   = ($urandom % 3 == 0) ? wreg : 5'($urandom);
      end
      @(negedge clk);
      drive(we, wreg, wdata, r1, r2);
      #1;
      check($sformatf("rand%0d_rd1_x%0d", i, r1), rd_data_1, model[r1]);
      check($sformatf("rand%0d_rd2_x%0d", i, r2), rd_data_2, model[r2]);
      @(posedge clk);
      if (we && wreg != 5'd0) model[wreg] = wdata;
    end

    @(negedge clk);
    wr_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
